// File: rtl/ofdm_clk_pkg.sv
// rtl/ofdm_clk_pkg.sv - shared state encodings and default timing for the OFDM clock/reset domain
// PLL_RETRY_LIMIT_EN adds the FAULT encoding.
package ofdm_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
`ifdef PLL_RETRY_LIMIT_EN
    ,
    ST_FAULT     = 3'd5
`endif
  } seq_state_t;

  localparam int MAX_RETRIES          = 8;

  localparam int DEF_N_STAGES         = 4;
  localparam int DEF_PLL_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT     = 1024;
  localparam int DEF_LOCK_STABLE      = 64;
  localparam int DEF_STAGE_GAP        = 8;
  localparam int DEF_CNT_W            = 16;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock/reset and datapath stage-reset signal bundle
// PLL_RETRY_LIMIT_EN adds pll_fault.
interface pll_reset_sequencer_if
  import ofdm_clk_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES
);

  logic                pll_locked;
  logic                pll_rst;
  logic [N_STAGES-1:0] stage_rst_n;
  logic                sys_ready;
  logic                lock_lost;
  logic                lock_lost_clr;
  logic [2:0]          state_dbg;
`ifdef PLL_RETRY_LIMIT_EN
  logic                pll_fault;
`endif

  modport master (
    input  pll_locked,
    input  lock_lost_clr,
    output pll_rst,
    output stage_rst_n,
    output sys_ready,
    output lock_lost,
`ifdef PLL_RETRY_LIMIT_EN
    output pll_fault,
`endif
    output state_dbg
  );

  modport slave (
    output pll_locked,
    output lock_lost_clr,
    input  pll_rst,
    input  stage_rst_n,
    input  sys_ready,
    input  lock_lost,
`ifdef PLL_RETRY_LIMIT_EN
    input  pll_fault,
`endif
    input  state_dbg
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer, asynchronous active-low reset to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL start-up and ordered datapath reset release with lock-loss recovery
// PLL_RETRY_LIMIT_EN enables the retry limit, FAULT state and pll_fault.
module pll_reset_sequencer
  import ofdm_clk_pkg::*;
#(
  parameter int N_STAGES       = DEF_N_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reset_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(N_STAGES + 1);

  localparam logic [CNT_W-1:0] C_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] C_GAP     = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);

  seq_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_sat;
  logic [IDX_W-1:0]    idx;
  logic                lock_s;
  logic                pll_rst_q;
  logic [N_STAGES-1:0] stage_q;
  logic                ready_q;
  logic                lost_q;
`ifdef PLL_RETRY_LIMIT_EN
  logic [3:0]          retry_cnt;
  logic                fault_q;
`endif

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.pll_locked),
    .q     (lock_s)
  );

  // Holds at all-ones rather than wrapping back into a compare value.
  assign cnt_sat = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PLL_RESET;
      cnt       <= '0;
      idx       <= '0;
      pll_rst_q <= 1'b1;
      stage_q   <= '0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
      retry_cnt <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      cnt <= cnt_sat;
      if (bus.lock_lost_clr) begin
        lost_q <= 1'b0;
      end

      case (state)
        ST_PLL_RESET: begin
          pll_rst_q <= 1'b1;
          if (cnt == C_PLL_RST) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == C_TIMEOUT) begin
            cnt       <= '0;
            pll_rst_q <= 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
            if (retry_cnt == 4'(MAX_RETRIES - 1)) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state     <= ST_PLL_RESET;
              retry_cnt <= retry_cnt + 4'd1;
            end
`else
            state <= ST_PLL_RESET;
`endif
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == C_STABLE) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            // Lock loss: slam every stage back into reset and restart the PLL.
            state     <= ST_PLL_RESET;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            stage_q   <= '0;
            ready_q   <= 1'b0;
            lost_q    <= 1'b1;
          end else if (state == ST_RELEASE && cnt == C_GAP) begin
            cnt     <= '0;
            stage_q <= stage_q | (N_STAGES'(1) << idx);
            if (idx == LAST_IDX) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
              retry_cnt <= '0;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

`ifdef PLL_RETRY_LIMIT_EN
        ST_FAULT: begin
          // Terminal until reset_n; keep the PLL and datapath held in reset.
          pll_rst_q <= 1'b1;
          stage_q   <= '0;
          ready_q   <= 1'b0;
          fault_q   <= 1'b1;
          cnt       <= '0;
        end
`endif

        default: begin
          state     <= ST_PLL_RESET;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
          stage_q   <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.stage_rst_n = stage_q;
  assign bus.sys_ready   = ready_q;
  assign bus.lock_lost   = lost_q;
  assign bus.state_dbg   = state;
`ifdef PLL_RETRY_LIMIT_EN
  assign bus.pll_fault   = fault_q;
`endif

endmodule
